// File: rtl/stage_4_pkg.sv
// Shared constants, FSM encoding and access-width helpers for the memory stage.
package stage_4_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  // Byte lanes touched by an access; width is func_3[1:0] (byte/half/word).
  function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] a);
    case (width)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the memory picks it up by be alone.
  function automatic logic [31:0] store_wdata(input logic [1:0] width, input logic [31:0] rs2);
    case (width)
      2'b00:   return {4{rs2[7:0]}};
      2'b01:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  // Illegal width code or misaligned address for the given access direction.
  function automatic logic access_bad(input logic is_load, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic illegal;
    logic misaligned;
    if (is_load) illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else         illegal = (f3 > F3_SW);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/stage_4_load_align.sv
// Combinational load-data extraction: selects the addressed byte/half and extends it.
module load_align
  import stage_4_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a_lo,
  input  logic [2:0]  func_3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign or zero extension chosen by func_3.
  always_comb begin
    byte_sel = rdata[{a_lo, 3'b000} +: 8];
    half_sel = a_lo[1] ? rdata[31:16] : rdata[15:0];
    case (func_3)
      F3_LB:   result = sext8(byte_sel);
      F3_LH:   result = sext16(half_sel);
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/stage_4.sv
// Memory stage: pass-through results in one cycle, loads/stores via a req/ack handshake.
module stage_4
  import stage_4_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        valid_out,
  output logic        wb_en,
  output logic [4:0]  rd_num,
  output logic [31:0] wb_data,
  output logic        fault
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]  a_lo_p1;
  logic [2:0]  f3_p1;
  logic [31:0] load_data;

  logic accept, is_load, is_store, is_mem, bad;
  logic mem_go, mem_bad, pass, ack_hit, timeout;

  assign accept   = i_valid && (state == S_IDLE);
  assign is_load  = i_op_type && (i_opcode == OP_LOAD);
  assign is_store = i_op_type && (i_opcode == OP_STORE);
  assign is_mem   = is_load || is_store;
  assign bad      = access_bad(is_load, i_func_3, i_alu_out[1:0]);
  assign mem_go   = accept && is_mem && !bad;
  assign mem_bad  = accept && is_mem && bad;
  assign pass     = accept && !is_mem;
  assign ack_hit  = (state == S_REQ) && mem_ack;
  assign timeout  = (state == S_REQ) && !mem_ack && (cnt == CNT_LAST);

  assign mem_req  = (state == S_REQ);
  assign stall    = (state != S_IDLE);

  load_align u_load_align (
    .rdata  (mem_rdata),
    .a_lo   (a_lo_p1),
    .func_3 (f3_p1),
    .result (load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: ack wins over timeout on the final wait cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mem_go) state_nxt = S_REQ;
      S_REQ: begin
        if (mem_ack)      state_nxt = S_DONE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait-cycle counter, cleared whenever the stage is not waiting on memory.
  always_ff @(posedge clk) begin
    if (rst || (state != S_REQ)) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  // Request fields are captured at acceptance; results land at accept or ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      valid_out <= 1'b0;
      wb_en     <= 1'b0;
      rd_num    <= '0;
      wb_data   <= '0;
      fault     <= 1'b0;
      a_lo_p1   <= '0;
      f3_p1     <= '0;
    end else begin
      valid_out <= pass || ack_hit;
      wb_en     <= (pass && (i_rd_num != 5'd0)) || (ack_hit && !mem_we && (rd_num != 5'd0));
      fault     <= mem_bad || timeout;
      if (pass) begin
        wb_data <= i_alu_out;
        rd_num  <= i_rd_num;
      end
      if (mem_go) begin
        mem_addr  <= {i_alu_out[31:2], 2'b00};
        mem_be    <= lane_be(i_func_3[1:0], i_alu_out[1:0]);
        mem_we    <= is_store;
        mem_wdata <= is_store ? store_wdata(i_func_3[1:0], i_rs_2) : 32'h0;
        rd_num    <= i_rd_num;
        a_lo_p1   <= i_alu_out[1:0];
        f3_p1     <= i_func_3;
      end
      if (ack_hit) wb_data <= mem_we ? 32'h0 : load_data;
    end
  end

endmodule

// File: tb/tb_stage_4.sv
// Self-checking bench for stage_4: directed corner cases plus randomized traffic
// compared against an arithmetic model of the access rules.
module tb_stage_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_alu_out;
  logic [31:0] i_rs_2;
  logic [4:0]  i_rd_num;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic        i_op_type;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, valid_out, wb_en, fault;
  logic [4:0]  rd_num;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  stage_4 #(.ACK_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_alu_out(i_alu_out), .i_rs_2(i_rs_2),
    .i_rd_num(i_rd_num), .i_opcode(i_opcode), .i_func_3(i_func_3), .i_op_type(i_op_type),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .valid_out(valid_out), .wb_en(wb_en), .rd_num(rd_num), .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    if (st) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    if (!legal) return 1'b1;
    return (addr % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int v;
    v = ((1 << m_size(f3)) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (m_size(f3) == 1) return (rs2 & 32'hFF) * 32'h01010101;
    if (m_size(f3) == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] mask, val;
    int sz;
    sz = m_size(f3);
    if (sz == 4) return rdata;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    val  = (rdata >> (8 * (addr % 4))) & mask;
    if (f3 < 4 && (val & ((mask >> 1) + 1)) != 0) val = val | ~mask;
    return val;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_valid = 0; i_op_type = 0; i_opcode = ALU; i_func_3 = 0;
    i_alu_out = 0; i_rs_2 = 0; i_rd_num = 0;
  endtask

  task automatic drive_op(input bit mem, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd);
    i_valid = 1; i_op_type = mem; i_opcode = mem ? (st ? STORE : LOAD) : ALU;
    i_func_3 = f3; i_alu_out = a; i_rs_2 = rs2; i_rd_num = rd;
  endtask

  // One legal memory access; ack arrives in the (delay+1)-th request cycle.
  task automatic do_mem(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [31:0] rdata, input int delay, input string tag);
    logic [31:0] e_addr;
    e_addr = addr & 32'hFFFF_FFFC;
    drive_op(1, st, f3, addr, rs2, rd);
    step();
    for (int k = 0; k <= delay; k++) begin
      // Unrelated upstream activity while stalled must be ignored.
      drive_op(0, 0, 3'($urandom), $urandom, $urandom, 5'($urandom));
      n_cmp++;
      if ({mem_req, stall, mem_we} !== {2'b11, st}) begin
        n_bad++;
        $display("FAIL %s req/stall/we cyc%0d got %b%b%b want 11%b", tag, k, mem_req, stall, mem_we, st);
      end
      n_cmp++;
      if ({mem_addr, mem_be} !== {e_addr, m_be(f3, addr)}) begin
        n_bad++;
        $display("FAIL %s addr/be cyc%0d got %h/%b want %h/%b", tag, k, mem_addr, mem_be, e_addr, m_be(f3, addr));
      end
      if (st) begin
        n_cmp++;
        if (mem_wdata !== m_wdata(f3, rs2)) begin
          n_bad++;
          $display("FAIL %s wdata cyc%0d got %h want %h", tag, k, mem_wdata, m_wdata(f3, rs2));
        end
      end
      if (k == delay) begin mem_ack = 1; mem_rdata = rdata; end
      step();
    end
    mem_ack = 0; mem_rdata = $urandom;
    n_cmp++;
    if ({valid_out, wb_en, rd_num, mem_req, stall} !== {1'b1, !st && rd != 0, rd, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL %s done v/en/rd/req/stall got %b%b %0d %b%b want 1%b %0d 01", tag,
               valid_out, wb_en, rd_num, mem_req, stall, !st && rd != 0, rd);
    end
    if (!st) begin
      n_cmp++;
      if (wb_data !== m_load(f3, addr, rdata)) begin
        n_bad++;
        $display("FAIL %s load data got %h want %h", tag, wb_data, m_load(f3, addr, rdata));
      end
    end
    drive_idle();
    step();
    n_cmp++;
    if ({valid_out, stall, mem_req, fault} !== 4'b0000) begin
      n_bad++;
      $display("FAIL %s after done v/stall/req/fault got %b%b%b%b want 0000", tag, valid_out, stall, mem_req, fault);
    end
  endtask

  task automatic do_fault(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input string tag);
    drive_op(1, st, f3, addr, $urandom, 5'd7);
    step();
    drive_idle();
    n_cmp++;
    if ({fault, mem_req, valid_out, stall} !== 4'b1000) begin
      n_bad++;
      $display("FAIL %s fault/req/v/stall got %b%b%b%b want 1000", tag, fault, mem_req, valid_out, stall);
    end
    step();
    n_cmp++;
    if ({fault, mem_req, valid_out} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s fault pulse width got %b%b%b want 000", tag, fault, mem_req, valid_out);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; drive_idle(); mem_ack = 0; mem_rdata = 0;
    step(); step();
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, valid_out, wb_en, rd_num, wb_data, fault} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs req=%b we=%b addr=%h be=%b wd=%h st=%b v=%b en=%b rd=%0d wb=%h f=%b want all 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, valid_out, wb_en, rd_num, wb_data, fault);
    end
    rst = 0;
  endtask

  task automatic test_add();
    drive_op(0, 0, 3'd0, 32'h1234, 32'h0, 5'd5);
    step();
    drive_idle();
    n_cmp++;
    if ({valid_out, wb_en, rd_num, wb_data, mem_req} !== {1'b1, 1'b1, 5'd5, 32'h1234, 1'b0}) begin
      n_bad++;
      $display("FAIL add v/en/rd/wb/req got %b%b %0d %h %b want 11 5 00001234 0", valid_out, wb_en, rd_num, wb_data, mem_req);
    end
    step();
    n_cmp++;
    if ({valid_out, mem_req} !== 2'b00) begin
      n_bad++;
      $display("FAIL add after got v=%b req=%b want 00", valid_out, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [4:0]  rd;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; rd = 5'($urandom_range(0, 31));
      mem_ack = 1'($urandom);
      drive_op(0, 0, 3'($urandom), a, $urandom, rd);
      i_opcode = 7'($urandom);
      step();
      n_cmp++;
      if ({valid_out, wb_en, rd_num, wb_data, stall, mem_req} !== {1'b1, rd != 0, rd, a, 2'b00}) begin
        n_bad++;
        $display("FAIL b2b[%0d] v/en/rd/wb/st/req got %b%b %0d %h %b%b want 1%b %0d %h 00", i,
                 valid_out, wb_en, rd_num, wb_data, stall, mem_req, rd != 0, rd, a);
      end
    end
    mem_ack = 0; drive_idle();
    step();
  endtask

  task automatic test_directed_mem();
    do_mem(1, 3'b000, 32'h103, 32'hAABBCCDD, 5'd9, 32'h0, 3, "sb_dir");
    n_cmp++;
    if (wb_en !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_dir idle wb_en got %b want 0", wb_en);
    end
    do_mem(0, 3'b000, 32'h202, 32'h0, 5'd3, 32'h00800000, 1, "lb_dir");
    do_mem(0, 3'b100, 32'h202, 32'h0, 5'd3, 32'h00800000, 0, "lbu_dir");
    do_mem(0, 3'b001, 32'h302, 32'h0, 5'd0, 32'h8001_7FFF, 2, "lh_rd0");
    do_fault(0, 3'b010, 32'h206, "lw_mis");
    do_fault(1, 3'b011, 32'h200, "st_ill");
    do_fault(0, 3'b110, 32'h200, "ld_ill");
  endtask

  task automatic test_random_mem();
    bit st;
    logic [2:0] f3;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom); f3 = 3'($urandom); addr = $urandom;
      if (m_fault(st, f3, addr)) do_fault(st, f3, addr, "rnd_fault");
      else do_mem(st, f3, addr, $urandom, 5'($urandom), $urandom, $urandom_range(0, 5), "rnd_mem");
    end
  endtask

  task automatic test_timeout();
    drive_op(1, 0, 3'b010, 32'h400, 32'h0, 5'd4);
    step();
    drive_idle();
    for (int c = 1; c <= 64; c++) begin
      n_cmp++;
      if ({mem_req, stall, fault} !== 3'b110) begin
        n_bad++;
        $display("FAIL timeout wait cyc%0d req/stall/fault got %b%b%b want 110", c, mem_req, stall, fault);
      end
      if (c < 64) step();
    end
    step();
    n_cmp++;
    if ({mem_req, fault, stall, valid_out} !== 4'b0100) begin
      n_bad++;
      $display("FAIL timeout expire req/fault/stall/v got %b%b%b%b want 0100", mem_req, fault, stall, valid_out);
    end
    for (int c = 66; c <= 71; c++) begin
      mem_ack = (c == 70);
      mem_rdata = 32'hDEAD_BEEF;
      step();
      n_cmp++;
      if ({mem_req, fault, stall, valid_out} !== 4'b0000) begin
        n_bad++;
        $display("FAIL timeout late ack cyc%0d req/fault/stall/v got %b%b%b%b want 0000", c, mem_req, fault, stall, valid_out);
      end
    end
    mem_ack = 0;
  endtask

  task automatic test_reset_in_req();
    drive_op(1, 1, 3'b010, 32'h500, 32'h1234_5678, 5'd6);
    step();
    drive_idle();
    step();
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_req pre req got %b want 1", mem_req);
    end
    rst = 1;
    step();
    rst = 0;
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, valid_out, wb_en, rd_num, wb_data, fault} !== '0) begin
      n_bad++;
      $display("FAIL rst_req outputs req=%b we=%b addr=%h be=%b wd=%h st=%b v=%b en=%b rd=%0d wb=%h f=%b want all 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, valid_out, wb_en, rd_num, wb_data, fault);
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    n_cmp++;
    if ({valid_out, stall, mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_req late ack v/stall/req got %b%b%b want 000", valid_out, stall, mem_req);
    end
    test_add();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_directed_mem();
    test_random_mem();
    test_timeout();
    test_reset_in_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_4.md
STAGE_4 -- requirements
Module: stage_4

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 64, meaning the maximum number of cycles waited for mem_ack before the access is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port i_valid, input, 1, meaning the execute-stage outputs are valid this cycle.
REQ-005 SHALL have port i_alu_out, input, 32, the result or effective address.
REQ-006 SHALL have port i_rs_2, input, 32, the store data.
REQ-007 SHALL have port i_rd_num, input, 5, the destination register.
REQ-008 SHALL have port i_opcode, input, 7, the instruction opcode (LOAD/STORE/other).
REQ-009 SHALL have port i_func_3, input, 3, the access width and signedness.
REQ-010 SHALL have port i_op_type, input, 1, where 1 means memory op and 0 means pass-through.
REQ-011 SHALL have port mem_req, output, 1, the data-memory request, held until ack.
REQ-012 SHALL have port mem_we, output, 1, where 1 means store.
REQ-013 SHALL have port mem_addr, output, 32, the word address, i.e. i_alu_out with bits [1:0] forced to 0.
REQ-014 SHALL have port mem_be, output, 4, the byte-lane enables.
REQ-015 SHALL have port mem_wdata, output, 32, the lane-replicated store data.
REQ-016 SHALL have port mem_ack, input, 1, meaning the memory accepted or completed the access.
REQ-017 SHALL have port mem_rdata, input, 32, the load word, valid with mem_ack.
REQ-018 SHALL have port stall, output, 1, meaning upstream holds its inputs and i_valid is ignored.
REQ-019 SHALL have port valid_out, output, 1, meaning the result is presented to writeback.
REQ-020 SHALL have port wb_en, output, 1, the register-write enable (loads and non-memory ops, rd_num!=0).
REQ-021 SHALL have port rd_num, output, 5, the registered destination register.
REQ-022 SHALL have port wb_data, output, 32, the writeback value.
REQ-023 SHALL have port fault, output, 1, a one-cycle pulse for misaligned, illegal func_3 or timeout.

Function
REQ-024 SHALL implement states IDLE, REQ, DONE; IDLE->REQ on an accepted memory op; REQ->DONE on mem_ack; REQ->IDLE on timeout; DONE->IDLE unconditionally.
REQ-025 SHALL, for a pass-through op accepted in IDLE, assert valid_out next cycle with wb_data=i_alu_out, giving 1-cycle latency and back-to-back throughput.
REQ-026 SHALL, for a memory op accepted in IDLE, raise mem_req on the next cycle, hold mem_req/mem_addr/mem_be/mem_wdata/mem_we stable until the mem_ack cycle, then drop mem_req on the following edge.
REQ-027 SHALL keep stall high while in REQ and DONE, and low otherwise.
REQ-028 SHALL assert valid_out for exactly one cycle in DONE; wb_en=1 for loads with rd_num!=0, 0 for stores.
REQ-029 SHALL generate store enables as follows: SB gives be=0001<<a[1:0] and wdata={4{rs2[7:0]}}; SH gives be=0011<<(2*a[1]) and wdata={2{rs2[15:0]}}; SW gives be=1111 and wdata=rs2.
REQ-030 SHALL extract load data by a[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word; loads drive be as in REQ-029.
REQ-031 SHALL treat H with a[0]=1, W with a[1:0]!=0, load func_3 in {011,110,111} and store func_3>=011 as faults: no mem_req, fault pulse next cycle, valid_out=0, stay IDLE.
REQ-032 SHALL count cycles in REQ; on reaching ACK_TIMEOUT without ack it SHALL drop mem_req, pulse fault and return to IDLE with no valid_out.
REQ-033 SHALL ignore mem_ack outside REQ.
REQ-034 SHALL ignore i_valid while stall=1; no input is lost because upstream holds its inputs.

Reset
REQ-035 SHALL, on rst high at a clock edge, enter IDLE, clear the timeout counter, and drive mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, valid_out, wb_en, rd_num, wb_data and fault to 0.
REQ-036 SHALL abandon any access in progress when rst is asserted in REQ: mem_req low after that edge, and a late mem_ack has no effect.

Structure
REQ-037 SHALL take the LOAD/STORE opcodes, the LB..LHU/SB..SW func_3 codes and the state encodings from constants.vh, and the sign-extension macro from utils.vh.
REQ-038 SHALL contain one combinational sub-module, load_align (rdata, a[1:0], func_3 -> 32-bit result).

Verification
REQ-039 SHALL cover: ADD result 0x1234 with rd=5 -> valid_out next cycle, wb_data=0x1234, wb_en=1, mem_req never asserted.
REQ-040 SHALL cover: SB rs2=0xAABBCCDD, addr 0x103 -> mem_addr=0x100, be=1000, wdata=0xDDDDDDDD, we=1; ack after 3 cycles -> valid_out with wb_en=0.
REQ-041 SHALL cover: LB addr 0x202 with rdata 0x00800000 -> wb_data=0xFFFFFF80; LBU at the same address -> wb_data=0x00000080.
REQ-042 SHALL cover: LW addr 0x206 -> fault pulse, no mem_req, no valid_out.
REQ-043 SHALL cover: LW with no ack for 64 cycles -> mem_req drops, fault pulses, stall clears; an ack on cycle 70 is ignored.
REQ-044 SHALL cover: rst during REQ -> all outputs 0 next cycle, and a following ADD completes normally.
